// File: rtl/cacheline_adapter.sv
// Converts one 256-bit cache-line request on the dfp port into a 4-beat x 64-bit burst on bmem.
// One transaction is outstanding at a time. Completion is signalled by a single-cycle dfp_resp.
module cacheline_adapter #(
  parameter int BEAT_W   = 64,
  parameter int BEATS    = 4,
  parameter int OFFSET_W = 5,
  localparam int LINE_W  = BEATS * BEAT_W,
  localparam int CNT_W   = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam logic [31:0]      ADDR_MASK = {{(32-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addr_buf;
  logic [LINE_W-1:0]  line_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_buf <= '0;
      line_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Write wins if both requests are seen together.
          if (dfp_write) begin
            addr_buf <= dfp_addr & ADDR_MASK;
            line_buf <= dfp_wdata;
            cnt      <= '0;
            state    <= WR_BURST;
          end else if (dfp_read) begin
            addr_buf <= dfp_addr & ADDR_MASK;
            state    <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            cnt   <= '0;
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bmem_rvalid) begin
            line_buf[cnt*BEAT_W +: BEAT_W] <= bmem_rdata;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_BEAT) state <= RESP;
          end
        end
        WR_BURST: begin
          if (bmem_ready) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_BEAT) state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Control strobes decode from state; data and address come straight from the buffers.
  assign bmem_read  = (state == RD_REQ);
  assign bmem_write = (state == WR_BURST);
  assign dfp_resp   = (state == RESP);
  assign bmem_addr  = addr_buf;
  assign bmem_wdata = line_buf[cnt*BEAT_W +: BEAT_W];
  assign dfp_rdata  = line_buf;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: reads, writes, backpressure, rvalid gaps and reset mid-burst.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read, dfp_write;
  logic [255:0] dfp_wdata, dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0]  bmem_wdata, bmem_rdata;

  always #5 clk = ~clk;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Handshake monitor: counts read commands, records accepted write beats, flags resp > 1 cycle.
  int          rd_cmds = 0;
  logic [63:0] wq[$];
  logic        prev_resp = 1'b0;
  logic        resp_double = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      prev_resp <= 1'b0;
    end else begin
      if (bmem_read && bmem_ready) rd_cmds <= rd_cmds + 1;
      if (bmem_write && bmem_ready) wq.push_back(bmem_wdata);
      if (dfp_resp && prev_resp) resp_double <= 1'b1;
      prev_resp <= dfp_resp;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp"},   256'(dfp_resp),   256'd0);
    chk({tag, "_rdata"},  dfp_rdata,        256'd0);
    chk({tag, "_bread"},  256'(bmem_read),  256'd0);
    chk({tag, "_bwrite"}, 256'(bmem_write), 256'd0);
    chk({tag, "_baddr"},  256'(bmem_addr),  256'd0);
    chk({tag, "_bwdata"}, 256'(bmem_wdata), 256'd0);
  endtask

  logic [63:0] ba[4], ea[4], ga[4], wa[4], xa[4], ya[4], za[4];
  logic        pat[7];
  logic        rp[6];
  int          ew[6];
  int          k;

  initial begin
    ba = '{64'hA000_0000_0000_000A, 64'hB000_0000_0000_000B,
           64'hC000_0000_0000_000C, 64'hD000_0000_0000_000D};
    wa = '{64'h1111_0000_0000_0000, 64'h2222_0000_0000_0001,
           64'h3333_0000_0000_0002, 64'h4444_0000_0000_0003};
    ea = '{64'hE0E0_E0E0_0000_0000, 64'hE1E1_E1E1_0000_0001,
           64'hE2E2_E2E2_0000_0002, 64'hE3E3_E3E3_0000_0003};
    ga = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
           64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_0F0F_F0F0};
    xa = '{64'h7000_0000_0000_0070, 64'h7100_0000_0000_0071,
           64'h7200_0000_0000_0072, 64'h7300_0000_0000_0073};
    ya = '{64'h9900_0000_0000_0000, 64'h9911_0000_0000_0000,
           64'h9922_0000_0000_0000, 64'h9933_0000_0000_0000};
    za = '{64'hAAAA_BBBB_CCCC_0000, 64'hAAAA_BBBB_CCCC_0001,
           64'hAAAA_BBBB_CCCC_0002, 64'hAAAA_BBBB_CCCC_0003};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    ew  = '{0, 1, 1, 2, 2, 3};

    // Reset
    rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Plain read, ready held high, back-to-back beats
    rd_cmds = 0;
    dfp_addr = 32'h1234_5678; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick();
    chk("rd1_cmd", 256'(bmem_read), 256'd1);
    chk("rd1_addr", 256'(bmem_addr), 256'h1234_5660);
    tick();
    chk("rd1_cmd_once", 256'(bmem_read), 256'd0);
    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1'b1; bmem_rdata = ba[i];
      tick();
    end
    bmem_rvalid = 1'b0; dfp_read = 1'b0;
    chk("rd1_resp", 256'(dfp_resp), 256'd1);
    chk("rd1_line", dfp_rdata, {ba[3], ba[2], ba[1], ba[0]});
    tick();
    chk("rd1_resp_end", 256'(dfp_resp), 256'd0);
    chk("rd1_ncmd", 256'(rd_cmds), 256'd1);

    // Write, then an allocate read the cycle after dfp_resp
    wq.delete();
    dfp_addr = 32'h8000_003F; dfp_wdata = {wa[3], wa[2], wa[1], wa[0]}; dfp_write = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr1_bwrite%0d", i), 256'(bmem_write), 256'd1);
      chk($sformatf("wr1_addr%0d", i), 256'(bmem_addr), 256'h8000_0020);
      chk($sformatf("wr1_wdata%0d", i), 256'(bmem_wdata), 256'(wa[i]));
      tick();
    end
    chk("wr1_resp", 256'(dfp_resp), 256'd1);
    dfp_write = 1'b0;
    tick();
    chk("wr1_resp_end", 256'(dfp_resp), 256'd0);
    chk("wr1_nbeats", 256'(wq.size()), 256'd4);
    dfp_addr = 32'h0000_1047; dfp_read = 1'b1;
    tick();
    chk("alloc_cmd", 256'(bmem_read), 256'd1);
    chk("alloc_addr", 256'(bmem_addr), 256'h0000_1040);
    tick();
    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1'b1; bmem_rdata = ea[i];
      tick();
    end
    bmem_rvalid = 1'b0; dfp_read = 1'b0;
    chk("alloc_resp", 256'(dfp_resp), 256'd1);
    chk("alloc_line", dfp_rdata, {ea[3], ea[2], ea[1], ea[0]});
    tick();

    // Read with RD_REQ backpressure and rvalid gaps, then a stray rvalid in IDLE
    rd_cmds = 0;
    bmem_ready = 1'b0; dfp_addr = 32'hCAFE_0BAD; dfp_read = 1'b1;
    tick();
    chk("rd2_cmd_c1", 256'(bmem_read), 256'd1);
    tick(); tick(); tick();
    chk("rd2_cmd_c4", 256'(bmem_read), 256'd1);
    chk("rd2_addr", 256'(bmem_addr), 256'hCAFE_0BA0);
    bmem_ready = 1'b1;
    tick();
    k = 0;
    for (int i = 0; i < 7; i++) begin
      bmem_rvalid = pat[i];
      bmem_rdata  = pat[i] ? ga[k] : 64'hDEAD_DEAD_DEAD_DEAD;
      if (pat[i]) k++;
      tick();
    end
    bmem_rvalid = 1'b0; dfp_read = 1'b0;
    chk("rd2_resp", 256'(dfp_resp), 256'd1);
    chk("rd2_line", dfp_rdata, {ga[3], ga[2], ga[1], ga[0]});
    tick();
    chk("rd2_ncmd", 256'(rd_cmds), 256'd1);
    bmem_rvalid = 1'b1; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    bmem_rvalid = 1'b0;
    chk("stray_line", dfp_rdata, {ga[3], ga[2], ga[1], ga[0]});
    chk("stray_no_cmd", 256'(bmem_read), 256'd0);

    // Write with ready toggling 1,0,1,0,1,1
    wq.delete();
    dfp_addr = 32'h0000_0100; dfp_wdata = {xa[3], xa[2], xa[1], xa[0]}; dfp_write = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bmem_ready = rp[i];
      chk($sformatf("wr2_bwrite%0d", i), 256'(bmem_write), 256'd1);
      chk($sformatf("wr2_wdata%0d", i), 256'(bmem_wdata), 256'(xa[ew[i]]));
      tick();
    end
    chk("wr2_resp", 256'(dfp_resp), 256'd1);
    dfp_write = 1'b0; bmem_ready = 1'b1;
    tick();
    chk("wr2_nbeats", 256'(wq.size()), 256'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("wr2_beat%0d", i), 256'(wq[i]), 256'(xa[i]));

    // Reset during write beat 2, then a normal read
    dfp_addr = 32'h4000_0000; dfp_wdata = {ya[3], ya[2], ya[1], ya[0]}; dfp_write = 1'b1;
    tick(); tick(); tick();
    chk("wr3_beat2", 256'(bmem_wdata), 256'(ya[2]));
    rst = 1'b1; dfp_write = 1'b0;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    dfp_addr = 32'h5555_5555; dfp_read = 1'b1;
    tick();
    chk("rd3_cmd", 256'(bmem_read), 256'd1);
    chk("rd3_addr", 256'(bmem_addr), 256'h5555_5540);
    tick();
    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1'b1; bmem_rdata = za[i];
      tick();
    end
    bmem_rvalid = 1'b0; dfp_read = 1'b0;
    chk("rd3_resp", 256'(dfp_resp), 256'd1);
    chk("rd3_line", dfp_rdata, {za[3], za[2], za[1], za[0]});
    tick();
    chk("rd3_resp_end", 256'(dfp_resp), 256'd0);
    chk("resp_single_cycle", 256'(resp_double), 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Responder for the cache's downward-facing line port (dfp_*). It accepts one 256-bit line read or write at a time and converts it into a 4-beat x 64-bit burst on the banked memory port (bmem_*).
- It returns the assembled line together with a single-cycle dfp_resp.
- It sits between the L1 cache and the burst memory model / DRAM controller, with one outstanding transaction.

Parameters:
BEAT_W, 64, width of one memory beat in bits
BEATS, 4, beats per line; LINE_W = BEATS*BEAT_W = 256 must equal the dfp data width
OFFSET_W, 5, line-offset bits zeroed on the outgoing address (log2 of LINE_W/8)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
dfp_addr  in  32  line address from cache; held stable while request is high
dfp_read  in  1  line read request; held high until dfp_resp
dfp_write  in  1  line write request; held high until dfp_resp
dfp_wdata  in  256  line write data; stable while dfp_write high
dfp_rdata  out  256  assembled read line; valid when dfp_resp=1
dfp_resp  out  1  one-cycle completion pulse
bmem_addr  out  32  burst base address, line-aligned
bmem_read  out  1  burst read command
bmem_write  out  1  burst write beat valid
bmem_wdata  out  64  write beat data
bmem_ready  in  1  memory accepts the command/beat this cycle
bmem_rdata  in  64  read beat data
bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset values:
  - state=IDLE, beat counter=0, address/line buffers=0.
  - All outputs 0: dfp_resp, dfp_rdata, bmem_read, bmem_write, bmem_addr, bmem_wdata.
- Control outputs are decoded combinationally from the registered state. Data and address outputs come from registered buffers.
- Five states: IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP.
- IDLE:
  - If dfp_write: latch {dfp_addr[31:5],5'b0} and dfp_wdata, set cnt=0, go to WR_BURST.
  - Else if dfp_read: latch the aligned address, go to RD_REQ.
  - Write has priority if both are high (illegal from the cache, but the behaviour is defined).
  - bmem_rvalid is ignored.
- RD_REQ:
  - bmem_read=1, bmem_addr=latched address.
  - Stay until bmem_ready=1; then go to RD_WAIT with cnt=0.
  - Exactly one cycle of bmem_read=1 with bmem_ready=1 per line read.
- RD_WAIT:
  - Each cycle with bmem_rvalid=1: line_buf[cnt*64 +: 64] <= bmem_rdata, cnt++.
  - When cnt==3 and bmem_rvalid=1, go to RESP.
  - Gaps (rvalid=0) may occur between beats; the counter holds during gaps.
- WR_BURST:
  - bmem_write=1, bmem_addr=latched address (constant for all beats), bmem_wdata=line_buf[cnt*64 +: 64].
  - cnt advances only when bmem_ready=1.
  - After beat 3 is accepted, go to RESP.
  - With bmem_ready=0, all bmem outputs hold.
- RESP:
  - dfp_resp=1 for exactly one cycle; dfp_rdata=line_buf. For writes this is the written line, which the cache treats as don't-care.
  - Unconditionally return to IDLE.
  - A new request may be accepted in the following IDLE cycle. This covers writeback followed immediately by allocate.
- Latency (bmem_ready held 1):
  - Read: request seen in IDLE at cycle N, bmem_read at N+1, resp one cycle after the 4th rvalid.
  - Write: beats at N+1..N+4, dfp_resp at N+5.
- Counter is 2 bits and wraps 3->0 on the terminal beat. No beat beyond BEATS is ever issued or captured.
- bmem_rvalid outside RD_WAIT is ignored: no buffer change, no error.
- Reset mid-transaction: synchronous return to the reset state, no dfp_resp and no further bmem activity. The cache is reset concurrently.
- dfp_read/dfp_write deasserting mid-transaction is a protocol violation. The transaction still completes and dfp_resp still pulses.

Test Plan:
- Read, ready=1, dfp_addr=0x1234_5678: bmem_addr=0x1234_5660 for one cycle. Beats 0x0..0A, 0x..0B, 0x..0C, 0x..0D arrive back-to-back. The cycle after beat 3, dfp_resp=1 with dfp_rdata={D,C,B,A} (beat 0 in bits 63:0).
- Write, dfp_addr=0x8000_003F, wdata words W0..W3: bmem_addr=0x8000_0020 on 4 consecutive beats with wdata W0,W1,W2,W3. dfp_resp at cycle N+5.
- Backpressure: bmem_ready=0 for 3 cycles in RD_REQ, and toggled 1,0,1,0,1,1 during WR_BURST. Exactly one read command and exactly 4 write beats result, with no beat skipped or duplicated.
- rvalid gaps: beats with rvalid pattern 1,0,0,1,1,0,1, plus a stray rvalid while in IDLE. The line assembles correctly and the stray beat leaves the buffer unchanged.
- Writeback then allocate: dfp_write completes, then dfp_read rises the cycle after dfp_resp. The read is accepted immediately, and dfp_resp never lasts more than 1 cycle.
- rst asserted during write beat 2: the next cycle all outputs are 0 and state=IDLE. A new read then completes normally.
